// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants for the fetch/decode queue: NOP encoding, reset PC and the fill-PC helper.
package fetch_decode_queue_pkg;

  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  localparam logic [31:0] PC_RESET = 32'h1c00_0000;

  // PC shown in an empty lane, counting up from the reset vector.
  function automatic logic [31:0] fill_pc(input int unsigned lane);
    return PC_RESET + 32'(lane * 4);
  endfunction

endpackage

// File: rtl/fetch_decode_queue_lane_shift.sv
// Combinational down-shift of a head entry by k lanes; vacated upper lanes get NOP/0.
module fdq_lane_shift
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic [LANES*32-1:0]         i_inst,
  input  logic [LANES*32-1:0]         i_pc,
  input  logic [LANES-1:0]            i_mask,
  input  logic [LANES-1:0]            i_taken,
  input  logic [$clog2(LANES+1)-1:0]  i_k,
  output logic [LANES*32-1:0]         o_inst,
  output logic [LANES*32-1:0]         o_pc,
  output logic [LANES-1:0]            o_mask,
  output logic [LANES-1:0]            o_taken
);

  always_comb begin
    o_inst  = '0;
    o_pc    = '0;
    o_taken = '0;
    o_mask  = i_mask >> i_k;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i + 32'(i_k) < LANES) begin
        o_inst[32*i +: 32] = i_inst[32*(i + 32'(i_k)) +: 32];
        o_pc[32*i +: 32]   = i_pc[32*(i + 32'(i_k)) +: 32];
        o_taken[i]         = i_taken[i + 32'(i_k)];
      end else begin
        o_inst[32*i +: 32] = INST_NOP;
        o_pc[32*i +: 32]   = '0;
        o_taken[i]         = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic packet buffer between fetch and decode; decode retires 0..LANES lanes per cycle.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EXCW  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*32-1:0]          in_inst,
  input  logic [LANES*32-1:0]          in_pc,
  input  logic [LANES-1:0]             in_lane_mask,
  input  logic [LANES-1:0]             in_pred_taken,
  input  logic [31:0]                  in_pred_target,
  input  logic [EXCW-1:0]              in_excp,
  input  logic [31:0]                  in_badv,
  output logic                         out_valid,
  output logic [LANES*32-1:0]          out_inst,
  output logic [LANES*32-1:0]          out_pc,
  output logic [LANES-1:0]             out_lane_mask,
  output logic [LANES-1:0]             out_pred_taken,
  output logic [31:0]                  out_pred_target,
  output logic [EXCW-1:0]              out_excp,
  output logic [31:0]                  out_badv,
  input  logic [$clog2(LANES+1)-1:0]   out_consume,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CW = $clog2(LANES+1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [LANES*32-1:0] r_inst   [DEPTH];
  logic [LANES*32-1:0] r_pc     [DEPTH];
  logic [LANES-1:0]    r_mask   [DEPTH];
  logic [LANES-1:0]    r_taken  [DEPTH];
  logic [31:0]         r_target [DEPTH];
  logic [EXCW-1:0]     r_excp   [DEPTH];
  logic [31:0]         r_badv   [DEPTH];

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [OW-1:0] r_occ;

  logic [LANES*32-1:0] w_sh_inst;
  logic [LANES*32-1:0] w_sh_pc;
  logic [LANES-1:0]    w_sh_mask;
  logic [LANES-1:0]    w_sh_taken;
  logic [CW-1:0]       w_cnt;
  logic [CW-1:0]       w_k;
  logic                w_valid;
  logic                w_wr;
  logic                w_pop;
  logic                w_shift;

  assign w_valid   = (r_occ != '0);
  assign in_ready  = (r_occ < OW'(DEPTH));
  assign occupancy = r_occ;
  assign out_valid = w_valid;
  assign w_wr      = in_valid && in_ready && !flush;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_cnt = w_cnt + CW'(r_mask[r_rd_ptr][i]);
    end
  end

  // An excepting head leaves as a whole once any lane is retired; a maskless bubble on any consume.
  assign w_k     = (out_consume < w_cnt) ? out_consume : w_cnt;
  assign w_pop   = w_valid && (out_consume != '0) &&
                   ((w_k == w_cnt) || (r_excp[r_rd_ptr] != '0));
  assign w_shift = w_valid && (out_consume != '0) && !w_pop;

  fdq_lane_shift #(.LANES(LANES)) u_shift (
    .i_inst  (r_inst[r_rd_ptr]),
    .i_pc    (r_pc[r_rd_ptr]),
    .i_mask  (r_mask[r_rd_ptr]),
    .i_taken (r_taken[r_rd_ptr]),
    .i_k     (w_k),
    .o_inst  (w_sh_inst),
    .o_pc    (w_sh_pc),
    .o_mask  (w_sh_mask),
    .o_taken (w_sh_taken)
  );

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      out_inst[32*i +: 32] = INST_NOP;
      out_pc[32*i +: 32]   = fill_pc(i);
    end
    out_lane_mask   = '0;
    out_pred_taken  = '0;
    out_pred_target = fill_pc(LANES);
    out_excp        = '0;
    out_badv        = PC_RESET;
    if (w_valid) begin
      out_inst        = r_inst[r_rd_ptr];
      out_pc          = r_pc[r_rd_ptr];
      out_lane_mask   = r_mask[r_rd_ptr];
      out_pred_taken  = r_taken[r_rd_ptr];
      out_pred_target = r_target[r_rd_ptr];
      out_excp        = r_excp[r_rd_ptr];
      out_badv        = r_badv[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_occ <= r_occ + OW'(w_wr) - OW'(w_pop);
    end
  end

  // A partial retire only happens with occupancy>0 and a write only below DEPTH, so the
  // head write-back and the tail write never target the same entry.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_wr) begin
        r_inst[r_wr_ptr]   <= in_inst;
        r_pc[r_wr_ptr]     <= in_pc;
        r_mask[r_wr_ptr]   <= in_lane_mask;
        r_taken[r_wr_ptr]  <= in_pred_taken;
        r_target[r_wr_ptr] <= in_pred_target;
        r_excp[r_wr_ptr]   <= in_excp;
        r_badv[r_wr_ptr]   <= in_badv;
      end
      if (w_shift) begin
        r_inst[r_rd_ptr]  <= w_sh_inst;
        r_pc[r_rd_ptr]    <= w_sh_pc;
        r_mask[r_rd_ptr]  <= w_sh_mask;
        r_taken[r_rd_ptr] <= w_sh_taken;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed plus random stimulus for fetch_decode_queue against a packet-queue reference model.
module tb_fetch_decode_queue;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EXCW  = 7;
  localparam logic [31:0] NOP   = 32'h0340_0000;
  localparam logic [31:0] PCR   = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [63:0] in_inst, in_pc, out_inst, out_pc;
  logic [1:0]  in_lane_mask, in_pred_taken, out_lane_mask, out_pred_taken, out_consume;
  logic [31:0] in_pred_target, in_badv, out_pred_target, out_badv;
  logic [6:0]  in_excp, out_excp;
  logic        out_valid;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic [63:0] inst;
    logic [63:0] pc;
    logic [1:0]  mask;
    logic [1:0]  taken;
    logic [31:0] tgt;
    logic [6:0]  excp;
    logic [31:0] badv;
  } pkt_t;

  pkt_t q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .EXCW(EXCW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_lane_mask(in_lane_mask),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_excp(in_excp), .in_badv(in_badv), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_lane_mask(out_lane_mask), .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target), .out_excp(out_excp), .out_badv(out_badv),
    .out_consume(out_consume), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input logic [1:0] mask, input logic [6:0] excp);
    pkt_t p;
    p.inst  = {$urandom, $urandom};
    p.pc    = {pc + 32'd4, pc};
    p.mask  = mask;
    p.taken = 2'($urandom) & mask;
    p.tgt   = $urandom;
    p.excp  = excp;
    p.badv  = $urandom;
    return p;
  endfunction

  task automatic put(input pkt_t p);
    in_valid       = 1'b1;
    in_inst        = p.inst;
    in_pc          = p.pc;
    in_lane_mask   = p.mask;
    in_pred_taken  = p.taken;
    in_pred_target = p.tgt;
    in_excp        = p.excp;
    in_badv        = p.badv;
  endtask

  task automatic check_all(input string tag);
    pkt_t e;
    if (q.size() == 0) begin
      e = '{inst: {NOP, NOP}, pc: {PCR + 32'd4, PCR}, mask: 2'b00, taken: 2'b00,
            tgt: PCR + 32'd8, excp: 7'd0, badv: PCR};
    end else begin
      e = q[0];
    end
    chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".inst"},  out_inst, e.inst);
    chk({tag, ".pc"},    out_pc, e.pc);
    chk({tag, ".mask"},  64'(out_lane_mask), 64'(e.mask));
    chk({tag, ".taken"}, 64'(out_pred_taken), 64'(e.taken));
    chk({tag, ".tgt"},   64'(out_pred_target), 64'(e.tgt));
    chk({tag, ".excp"},  64'(out_excp), 64'(e.excp));
    chk({tag, ".badv"},  64'(out_badv), 64'(e.badv));
    chk({tag, ".occ"},   64'(occupancy), 64'(q.size()));
    chk({tag, ".ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
  endtask

  // Reference: a queue of packets; retiring k lanes either drops the head or slides it down.
  task automatic model_step();
    bit   wr;
    int   n, k;
    pkt_t h;
    if (rst || flush) begin
      q.delete();
      return;
    end
    wr = in_valid && (q.size() < DEPTH);
    if (q.size() > 0 && out_consume != 0) begin
      h = q[0];
      n = $countones(h.mask);
      k = (int'(out_consume) < n) ? int'(out_consume) : n;
      if (k == n || h.excp != 0) begin
        void'(q.pop_front());
      end else begin
        for (int i = 0; i < 2; i++) begin
          h.inst[32*i +: 32] = (i + k < 2) ? q[0].inst[32*(i+k) +: 32] : NOP;
          h.pc[32*i +: 32]   = (i + k < 2) ? q[0].pc[32*(i+k) +: 32] : 32'd0;
          h.taken[i]         = (i + k < 2) ? q[0].taken[i+k] : 1'b0;
        end
        h.mask = q[0].mask >> k;
        q[0] = h;
      end
    end
    if (wr) begin
      assert (in_lane_mask != 2'b10) else $fatal(1, "illegal lane mask %b", in_lane_mask);
      q.push_back('{inst: in_inst, pc: in_pc, mask: in_lane_mask, taken: in_pred_taken,
                    tgt: in_pred_target, excp: in_excp, badv: in_badv});
    end
  endtask

  task automatic cyc(input string tag);
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; out_consume = 2'd0;
    in_inst = '0; in_pc = '0; in_lane_mask = '0; in_pred_taken = '0;
    in_pred_target = '0; in_excp = '0; in_badv = '0;
  endtask

  initial begin
    pkt_t p;
    logic [1:0] m;
    rst = 1'b1;
    idle();
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;

    // 1: reset / empty fill
    chk("t1.inst", out_inst, {NOP, NOP});
    chk("t1.pc", out_pc, {PCR + 32'd4, PCR});
    chk("t1.ready", 64'(in_ready), 64'd1);
    cyc("t1");

    // 2: single packet, full consume next cycle
    put(mk(32'h1c00_0000, 2'b11, 7'd0));
    cyc("t2a");
    idle(); out_consume = 2'd2;
    chk("t2.pc0", 64'(out_pc[31:0]), 64'h1c00_0000);
    cyc("t2b");
    idle();
    chk("t2.empty", 64'(out_valid), 64'd0);
    cyc("t2c");

    // 3: partial retire then final retire
    put(mk(32'h0000_0100, 2'b11, 7'd0));
    cyc("t3a");
    idle(); out_consume = 2'd1;
    cyc("t3b");
    chk("t3.pc0", 64'(out_pc[31:0]), 64'h104);
    chk("t3.mask", 64'(out_lane_mask), 64'h1);
    chk("t3.occ", 64'(occupancy), 64'd1);
    cyc("t3c");
    idle();
    chk("t3.pop", 64'(occupancy), 64'd0);
    cyc("t3d");

    // 4: fill to full, then stream with wrap
    for (int i = 0; i < 4; i++) begin
      put(mk(32'h200 + 32'(16*i), 2'b11, 7'd0));
      cyc("t4fill");
    end
    idle();
    chk("t4.full", 64'(in_ready), 64'd0);
    chk("t4.occ", 64'(occupancy), 64'd4);
    for (int i = 0; i < 10; i++) begin
      put(mk(32'h400 + 32'(16*i), 2'b11, 7'd0));
      out_consume = 2'd2;
      cyc("t4stream");
    end
    idle(); out_consume = 2'd2;
    for (int i = 0; i < 5; i++) cyc("t4drain");

    // 5: flush wins over write and consume
    idle();
    for (int i = 0; i < 3; i++) begin
      put(mk(32'h800 + 32'(16*i), 2'b11, 7'd0));
      cyc("t5fill");
    end
    put(mk(32'h900, 2'b11, 7'd0));
    flush = 1'b1; out_consume = 2'd2;
    chk("t5.occ3", 64'(occupancy), 64'd3);
    cyc("t5flush");
    idle();
    chk("t5.occ", 64'(occupancy), 64'd0);
    chk("t5.valid", 64'(out_valid), 64'd0);
    cyc("t5after");

    // 6: excepting head pops on partial consume
    put(mk(32'hA00, 2'b11, 7'h08));
    cyc("t6a");
    put(mk(32'hB00, 2'b11, 7'd0));
    cyc("t6b");
    idle(); out_consume = 2'd1;
    chk("t6.excp", 64'(out_excp), 64'h08);
    cyc("t6c");
    chk("t6.next", 64'(out_pc[31:0]), 64'hB00);
    out_consume = 2'd2;
    cyc("t6d");

    // random phase
    for (int i = 0; i < 400; i++) begin
      idle();
      case ($urandom_range(0, 2))
        0:       m = 2'b00;
        1:       m = 2'b01;
        default: m = 2'b11;
      endcase
      p = mk($urandom & 32'hffff_fffc, m, ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0);
      if ($urandom_range(0, 2) != 0) put(p);
      out_consume = 2'($urandom_range(0, 2));
      flush = ($urandom_range(0, 29) == 0);
      cyc("rnd");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
